// File: rtl/renkon_conv_ctrl_if.sv
// Bundle between the conv sequencer, the layer controller and the tree/operand buffers.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a plain level or a single-cycle pulse.
interface renkon_conv_ctrl_if #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 5,
    parameter int SWIDTH = 8,
    parameter int CWIDTH = 10
);
    // layer controller side
    logic                     req;
    logic [LWIDTH-1:0]        qbits;
    logic [SWIDTH-1:0]        in_size;
    logic [CWIDTH-1:0]        n_in;
    logic                     busy;
    logic                     ack;
    // tree and operand buffer side
    logic signed [DWIDTH-1:0] fmap;
    logic [LWIDTH-1:0]        tree_qbits;
    logic                     win_valid;
    logic [SWIDTH-1:0]        win_row;
    logic [SWIDTH-1:0]        win_col;
    logic [CWIDTH-1:0]        win_ch;
    // finished output pixels
    logic                     out_valid;
    logic signed [DWIDTH-1:0] out_data;
    logic [SWIDTH-1:0]        out_row;
    logic [SWIDTH-1:0]        out_col;

    modport master (
        input  req, qbits, in_size, n_in, fmap,
        output busy, ack, tree_qbits, win_valid, win_row, win_col, win_ch,
               out_valid, out_data, out_row, out_col
    );

    modport slave (
        output req, qbits, in_size, n_in, fmap,
        input  busy, ack, tree_qbits, win_valid, win_row, win_col, win_ch,
               out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/renkon_conv_ctrl.sv
// Walks every valid 5x5 window (row, col, channel inner), tracks it through the buffer+tree pipe, sums channels into one pixel.
// Latency: first window 1 cycle after req; out_valid BUF_LAT+TREE_LAT+1 cycles after a position's last-channel window; ack 1 cycle after the final out_valid.
// Backpressure: none, one window per cycle while running. Build macro RENKON_ACCUM_SAT_EN selects saturating accumulation (default wraps).
module renkon_conv_ctrl #(
    parameter int DWIDTH   = 16,
    parameter int LWIDTH   = 5,
    parameter int SWIDTH   = 8,
    parameter int CWIDTH   = 10,
    parameter int BUF_LAT  = 1,
    parameter int TREE_LAT = 5
) (
    input logic                clk,
    input logic                xrst,
    renkon_conv_ctrl_if.master bus
);
    localparam int PIPE_LAT = BUF_LAT + TREE_LAT;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Tag travelling alongside each window so the tail knows how to treat the tree output.
    typedef struct packed {
        logic              first;
        logic              last;
        logic [SWIDTH-1:0] row;
        logic [SWIDTH-1:0] col;
    } tag_t;

    logic [1:0]               state;
    logic [LWIDTH-1:0]        qbits_q;
    logic [SWIDTH-1:0]        out_size_q;
    logic [CWIDTH-1:0]        n_in_q;
    logic [SWIDTH-1:0]        row_q;
    logic [SWIDTH-1:0]        col_q;
    logic [CWIDTH-1:0]        ch_q;
    logic                     issue;
    logic                     ch_last;
    logic                     col_last;
    logic                     row_last;
    logic [PIPE_LAT-1:0]      pipe_vld;
    tag_t                     pipe_tag [PIPE_LAT];
    tag_t                     tail;
    logic                     tail_vld;
    logic signed [DWIDTH-1:0] acc_q;
    logic signed [DWIDTH-1:0] add_res;
    logic signed [DWIDTH-1:0] sum;
    logic                     out_valid_q;
    logic signed [DWIDTH-1:0] out_data_q;
    logic [SWIDTH-1:0]        out_row_q;
    logic [SWIDTH-1:0]        out_col_q;

    assign issue    = (state == S_RUN);
    assign ch_last  = (ch_q == n_in_q - CWIDTH'(1));
    assign col_last = (col_q == out_size_q - SWIDTH'(1));
    assign row_last = (row_q == out_size_q - SWIDTH'(1));
    assign tail     = pipe_tag[PIPE_LAT-1];
    assign tail_vld = pipe_vld[PIPE_LAT-1];

    // Layer sequencing: accept a job, walk the window counters, wait for the pipe to empty, pulse ack.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= S_IDLE;
            qbits_q    <= '0;
            out_size_q <= '0;
            n_in_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            ch_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        qbits_q    <= bus.qbits;
                        // zero channels is treated as a single-channel layer
                        n_in_q     <= (bus.n_in == '0) ? CWIDTH'(1) : bus.n_in;
                        out_size_q <= bus.in_size - SWIDTH'(4);
                        row_q      <= '0;
                        col_q      <= '0;
                        ch_q       <= '0;
                        // a map smaller than the kernel has no valid window at all
                        state      <= (bus.in_size < SWIDTH'(5)) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (ch_last) begin
                        ch_q <= '0;
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q <= '0;
                                state <= S_DRAIN;
                            end else begin
                                row_q <= row_q + SWIDTH'(1);
                            end
                        end else begin
                            col_q <= col_q + SWIDTH'(1);
                        end
                    end else begin
                        ch_q <= ch_q + CWIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    // the final tail consumption registers out_valid on the same edge the pipe empties
                    if (pipe_vld == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Delay line matching the buffer+tree latency; tail lines up with fmap for the same window.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            pipe_vld <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld[0]       <= issue;
            pipe_tag[0].first <= (ch_q == '0);
            pipe_tag[0].last  <= ch_last;
            pipe_tag[0].row   <= row_q;
            pipe_tag[0].col   <= col_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

`ifdef RENKON_ACCUM_SAT_EN
    localparam logic signed [DWIDTH-1:0] ACC_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] ACC_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
    logic [DWIDTH:0] sum_ext;

    // Channel add clamped to the signed range; a clamped value is what carries into the next channel.
    always_comb begin
        sum_ext = {acc_q[DWIDTH-1], acc_q} + {bus.fmap[DWIDTH-1], bus.fmap};
        if (sum_ext[DWIDTH] != sum_ext[DWIDTH-1]) begin
            add_res = sum_ext[DWIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            add_res = sum_ext[DWIDTH-1:0];
        end
    end
`else
    // Channel add with plain two's-complement wrap.
    always_comb begin
        add_res = acc_q + bus.fmap;
    end
`endif

    // The first channel of a position restarts the sum instead of adding to the previous pixel.
    assign sum = tail.first ? bus.fmap : add_res;

    // Accumulate at the pipe tail and register one finished pixel per position.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= tail_vld && tail.last;
            if (tail_vld) begin
                acc_q <= sum;
                if (tail.last) begin
                    out_data_q <= sum;
                    out_row_q  <= tail.row;
                    out_col_q  <= tail.col;
                end
            end
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.ack        = (state == S_DONE);
    assign bus.tree_qbits = qbits_q;
    assign bus.win_valid  = issue;
    assign bus.win_row    = row_q;
    assign bus.win_col    = col_q;
    assign bus.win_ch     = ch_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
endmodule
